// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: button-driven control FSM for a 4-digit BCD stopwatch with lap capture.
// Defining STOPWATCH_LAP_RECALL_EN adds a RECALL state for browsing stored laps from PAUSE.
module stopwatch_lap_ctrl #(
    parameter int LAP_DEPTH   = 4,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start_p,
    input  logic                       lap_p,
    input  logic [3:0]                 din0,
    input  logic [3:0]                 din1,
    input  logic [3:0]                 din2,
    input  logic [3:0]                 din3,
    output logic                       cnt_en,
    output logic                       cnt_clr,
    output logic [3:0]                 dout0,
    output logic [3:0]                 dout1,
    output logic [3:0]                 dout2,
    output logic [3:0]                 dout3,
    output logic [$clog2(LAP_DEPTH):0] lap_cnt,
    output logic                       lap_full,
    output logic [2:0]                 state
);
    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_FREEZE = 3'd2,
`ifdef STOPWATCH_LAP_RECALL_EN
        S_PAUSE  = 3'd3,
        S_RECALL = 3'd4
`else
        S_PAUSE  = 3'd3
`endif
    } state_t;

    state_t         state_reg;
    logic           cnt_en_reg;
    logic           cnt_clr_reg;
    logic [15:0]    disp_reg;
    logic [CW-1:0]  lap_cnt_reg;
    logic [HW-1:0]  hold_reg;
    logic [15:0]    din_w;
    logic           full_w;

    assign din_w  = {din3, din2, din1, din0};
    assign full_w = (lap_cnt_reg == CW'(LAP_DEPTH));

`ifdef STOPWATCH_LAP_RECALL_EN
    // lap_cnt doubles as the write pointer: it only grows until full, so it never wraps.
    logic [15:0]   slot [LAP_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic          wr_en;
    logic          rd_last;

    assign wr_en   = lap_p && !start_p && !full_w &&
                     (state_reg == S_RUN || state_reg == S_FREEZE);
    assign rd_last = ({1'b0, rd_ptr_reg} == lap_cnt_reg - CW'(1));

    generate
        for (genvar gi = 0; gi < LAP_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (wr_en && lap_cnt_reg[PW-1:0] == PW'(gi))
                    slot[gi] <= din_w;
            end
        end
    endgenerate
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= S_IDLE;
            cnt_en_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            disp_reg    <= '0;
            lap_cnt_reg <= '0;
            hold_reg    <= '0;
`ifdef STOPWATCH_LAP_RECALL_EN
            rd_ptr_reg  <= '0;
`endif
        end else begin
            cnt_clr_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cnt_en_reg <= 1'b0;
                    disp_reg   <= din_w;
                    if (start_p) begin
                        state_reg  <= S_RUN;
                        cnt_en_reg <= 1'b1;
                    end else if (lap_p) begin
                        cnt_clr_reg <= 1'b1;
                        lap_cnt_reg <= '0;
`ifdef STOPWATCH_LAP_RECALL_EN
                        rd_ptr_reg  <= '0;
`endif
                    end
                end
                S_RUN: begin
                    disp_reg <= din_w;
                    if (start_p) begin
                        state_reg  <= S_PAUSE;
                        cnt_en_reg <= 1'b0;
                    end else if (lap_p) begin
                        // The live value loaded into disp_reg becomes the frozen snapshot.
                        state_reg <= S_FREEZE;
                        hold_reg  <= HOLD_LOAD;
                        if (!full_w)
                            lap_cnt_reg <= lap_cnt_reg + CW'(1);
                    end
                end
                S_FREEZE: begin
                    if (start_p) begin
                        state_reg  <= S_PAUSE;
                        cnt_en_reg <= 1'b0;
                        disp_reg   <= din_w;
                    end else if (lap_p) begin
                        disp_reg <= din_w;
                        hold_reg <= HOLD_LOAD;
                        if (!full_w)
                            lap_cnt_reg <= lap_cnt_reg + CW'(1);
                    end else if (hold_reg == '0) begin
                        state_reg <= S_RUN;
                        disp_reg  <= din_w;
                    end else begin
                        hold_reg <= hold_reg - HW'(1);
                    end
                end
                S_PAUSE: begin
                    cnt_en_reg <= 1'b0;
                    disp_reg   <= din_w;
                    if (start_p) begin
                        state_reg  <= S_RUN;
                        cnt_en_reg <= 1'b1;
                    end else if (lap_p) begin
`ifdef STOPWATCH_LAP_RECALL_EN
                        if (lap_cnt_reg != '0) begin
                            state_reg  <= S_RECALL;
                            rd_ptr_reg <= '0;
                            disp_reg   <= slot[0];
                        end else begin
                            state_reg   <= S_IDLE;
                            cnt_clr_reg <= 1'b1;
                            lap_cnt_reg <= '0;
                            rd_ptr_reg  <= '0;
                        end
`else
                        state_reg   <= S_IDLE;
                        cnt_clr_reg <= 1'b1;
                        lap_cnt_reg <= '0;
`endif
                    end
                end
`ifdef STOPWATCH_LAP_RECALL_EN
                S_RECALL: begin
                    cnt_en_reg <= 1'b0;
                    if (start_p) begin
                        state_reg <= S_PAUSE;
                        disp_reg  <= din_w;
                    end else if (lap_p) begin
                        if (rd_last) begin
                            state_reg   <= S_IDLE;
                            cnt_clr_reg <= 1'b1;
                            lap_cnt_reg <= '0;
                            rd_ptr_reg  <= '0;
                            disp_reg    <= din_w;
                        end else begin
                            rd_ptr_reg <= rd_ptr_reg + PW'(1);
                            disp_reg   <= slot[rd_ptr_reg + PW'(1)];
                        end
                    end
                end
`endif
                default: begin
                    state_reg  <= S_IDLE;
                    cnt_en_reg <= 1'b0;
                    disp_reg   <= din_w;
                end
            endcase
        end
    end

    assign cnt_en   = cnt_en_reg;
    assign cnt_clr  = cnt_clr_reg;
    assign dout0    = disp_reg[3:0];
    assign dout1    = disp_reg[7:4];
    assign dout2    = disp_reg[11:8];
    assign dout3    = disp_reg[15:12];
    assign lap_cnt  = lap_cnt_reg;
    assign lap_full = full_w;
    assign state    = state_reg;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: directed and random stimulus against a queue-based stopwatch model.
// Follows STOPWATCH_LAP_RECALL_EN the same way the design does.
module tb_stopwatch_lap_ctrl;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_FREEZE = 2, M_PAUSE = 3, M_RECALL = 4;
`ifdef STOPWATCH_LAP_RECALL_EN
    localparam bit RECALL_ON = 1'b1;
`else
    localparam bit RECALL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        start_p;
    logic        lap_p;
    logic [15:0] din;
    logic        cnt_en;
    logic        cnt_clr;
    logic [3:0]  dout0, dout1, dout2, dout3;
    logic [2:0]  lap_cnt;
    logic        lap_full;
    logic [2:0]  state;
    logic [15:0] dout;

    assign dout = {dout3, dout2, dout1, dout0};

    stopwatch_lap_ctrl #(.LAP_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .clr(clr), .start_p(start_p), .lap_p(lap_p),
        .din0(din[3:0]), .din1(din[7:4]), .din2(din[11:8]), .din3(din[15:12]),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .lap_cnt(lap_cnt), .lap_full(lap_full), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode, list of stored laps, frozen snapshot, cycles elapsed since the last lap.
    int          m_state;
    logic [15:0] laps [$];
    logic [15:0] m_snap;
    int          m_since;
    int          m_idx;
    logic [15:0] e_disp;
    logic        e_en;
    logic        e_clr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        laps.delete();
        m_snap  = '0;
        m_since = 0;
        m_idx   = 0;
        e_disp  = '0;
        e_en    = 1'b0;
        e_clr   = 1'b0;
    endtask

    task automatic wipe();
        laps.delete();
        m_idx   = 0;
        e_clr   = 1'b1;
        m_state = M_IDLE;
    endtask

    task automatic capture(input logic [15:0] d);
        if (laps.size() < DEPTH) laps.push_back(d);
        m_snap  = d;
        m_since = 0;
        m_state = M_FREEZE;
    endtask

    task automatic model_step(input logic s, input logic l, input logic [15:0] d);
        e_clr = 1'b0;
        case (m_state)
            M_IDLE:   if (s) m_state = M_RUN; else if (l) wipe();
            M_RUN:    if (s) m_state = M_PAUSE; else if (l) capture(d);
            M_FREEZE: begin
                if (s) m_state = M_PAUSE;
                else if (l) capture(d);
                else begin
                    m_since++;
                    if (m_since == HOLD) m_state = M_RUN;
                end
            end
            M_PAUSE: begin
                if (s) m_state = M_RUN;
                else if (l) begin
                    if (RECALL_ON && laps.size() > 0) begin
                        m_state = M_RECALL;
                        m_idx   = 0;
                    end else wipe();
                end
            end
            M_RECALL: begin
                if (s) m_state = M_PAUSE;
                else if (l) begin
                    if (m_idx == laps.size() - 1) wipe();
                    else m_idx++;
                end
            end
            default: m_state = M_IDLE;
        endcase
        e_en = (m_state == M_RUN || m_state == M_FREEZE);
        if (m_state == M_FREEZE)      e_disp = m_snap;
        else if (m_state == M_RECALL) e_disp = laps[m_idx];
        else                          e_disp = d;
    endtask

    task automatic compare_model();
        check("state", 32'(state), 32'(m_state));
        check("cnt_en", 32'(cnt_en), 32'(e_en));
        check("cnt_clr", 32'(cnt_clr), 32'(e_clr));
        check("dout", 32'(dout), 32'(e_disp));
        check("lap_cnt", 32'(lap_cnt), 32'(laps.size()));
        check("lap_full", 32'(lap_full), 32'(laps.size() == DEPTH));
    endtask

    // Drive one cycle of inputs (from a negedge), advance the model at the posedge, compare at the next negedge.
    task automatic tick(input logic s, input logic l, input logic [15:0] d);
        start_p = s;
        lap_p   = l;
        din     = d;
        @(posedge clk);
        model_step(s, l, d);
        @(negedge clk);
        compare_model();
    endtask

    task automatic async_reset(input string name);
        clr = 1'b1;
        #1;
        check({name, "_state"}, 32'(state), 32'd0);
        check({name, "_cnt_en"}, 32'(cnt_en), 32'd0);
        check({name, "_dout"}, 32'(dout), 32'h0000);
        check({name, "_lap_cnt"}, 32'(lap_cnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    initial begin
        clr = 1'b1; start_p = 1'b0; lap_p = 1'b0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_state", 32'(state), 32'd0);
        check("init_dout", 32'(dout), 32'h0000);
        clr = 1'b0;

        // Start/stop and reset sequence
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'h0000);
        check("start_en", 32'(cnt_en), 32'd1);
        tick(1'b0, 1'b0, 16'h0123);
        tick(1'b1, 1'b0, 16'h0123);
        check("stop_en", 32'(cnt_en), 32'd0);
        check("stop_state", 32'(state), 32'd3);
        tick(1'b0, 1'b1, 16'h0123);
        check("rst_clr_hi", 32'(cnt_clr), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        tick(1'b0, 1'b0, 16'h0123);
        check("rst_clr_lo", 32'(cnt_clr), 32'd0);

        // Freeze timing: snapshot held for HOLD cycles while din advances
        tick(1'b1, 1'b0, 16'h0040);
        tick(1'b0, 1'b1, 16'h0042);
        check("frz_dout0", 32'(dout), 32'h0042);
        check("frz_lapcnt", 32'(lap_cnt), 32'd1);
        for (int i = 1; i < HOLD; i++) begin
            tick(1'b0, 1'b0, 16'h0042 + 16'(i));
            check("frz_hold", 32'(dout), 32'h0042);
        end
        tick(1'b0, 1'b0, 16'h0050);
        check("frz_live", 32'(dout), 32'h0050);
        check("frz_run", 32'(state), 32'd1);

        async_reset("midrun_rst");

        // Full buffer: fifth lap still freezes but is not stored
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 16'h0010);
        tick(1'b0, 1'b1, 16'h0020);
        tick(1'b0, 1'b1, 16'h0030);
        tick(1'b0, 1'b1, 16'h0040);
        tick(1'b0, 1'b1, 16'h0050);
        check("full_cnt", 32'(lap_cnt), 32'd4);
        check("full_flag", 32'(lap_full), 32'd1);
        check("full_dout", 32'(dout), 32'h0050);
        check("full_state", 32'(state), 32'd2);

        async_reset("full_rst");

        // Simultaneous start and lap in RUN: start wins
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b1, 1'b1, 16'h0077);
        check("simul_state", 32'(state), 32'd3);
        check("simul_cnt", 32'(lap_cnt), 32'd0);
        check("simul_dout", 32'(dout), 32'h0077);

        // Recall (or immediate reset without the feature)
        tick(1'b1, 1'b0, 16'h0000);
        tick(1'b0, 1'b1, 16'h0011);
        tick(1'b0, 1'b1, 16'h0022);
        tick(1'b1, 1'b0, 16'h0030);
        check("rec_pause", 32'(state), 32'd3);
`ifdef STOPWATCH_LAP_RECALL_EN
        tick(1'b0, 1'b1, 16'h0030);
        check("rec_slot0", 32'(dout), 32'h0011);
        check("rec_state", 32'(state), 32'd4);
        tick(1'b0, 1'b1, 16'h0030);
        check("rec_slot1", 32'(dout), 32'h0022);
        tick(1'b0, 1'b1, 16'h0030);
`else
        tick(1'b0, 1'b1, 16'h0030);
`endif
        check("rec_end_clr", 32'(cnt_clr), 32'd1);
        check("rec_end_state", 32'(state), 32'd0);
        check("rec_end_cnt", 32'(lap_cnt), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0, 16'($urandom));
            if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
- Control FSM for the stopwatch. Sits between the debounced button pulses and the BCD time counter plus display.
- Drives count enable and counter clear.
- Captures lap times into a LAP_DEPTH-entry buffer.
- Selects what the 4-digit display shows: live time, a frozen lap snapshot, or stored laps during recall.

Parameters:
- LAP_DEPTH, 4: number of lap slots; power of 2, range 2..16.
- HOLD_CYCLES, 100000000: cycles a frozen lap stays on the display before the display returns to live time.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start_p  in  1  one-cycle pulse, start/stop button.
- lap_p  in  1  one-cycle pulse, lap/reset button.
- din0..din3  in  4 each  live BCD time from the counter; din0 is the least significant digit.
- cnt_en  out  1  counter enable.
- cnt_clr  out  1  one-cycle counter clear pulse.
- dout0..dout3  out  4 each  display digits, registered.
- lap_cnt  out  $clog2(LAP_DEPTH)+1  number of stored laps.
- lap_full  out  1  high when lap_cnt == LAP_DEPTH.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE; cnt_en=0; cnt_clr=0; dout0..3=0.
  - lap_cnt=0; write pointer=0; read pointer=0; hold counter=0.
  - Buffer contents are don't-care.
- All outputs are registered.
  - In live-display states, dout equals din delayed by 1 cycle.
  - cnt_en changes on the edge that samples the button pulse.
- Priority: if start_p and lap_p are high in the same cycle, start_p is acted on and lap_p is dropped.
- States: IDLE=0, RUN=1, FREEZE=2, PAUSE=3, RECALL=4.
- IDLE: cnt_en=0, display live.
  - start_p -> RUN.
  - lap_p -> cnt_clr=1 for exactly one cycle; lap_cnt, write pointer and read pointer cleared; stay in IDLE.
- RUN: cnt_en=1, display live.
  - start_p -> PAUSE.
  - lap_p -> go to FREEZE, load the hold counter with HOLD_CYCLES-1, latch {din3..din0} as the snapshot. In the same cycle:
    - if not full: write {din3..din0} to slot[write pointer], increment write pointer and lap_cnt;
    - if full: no write, lap_cnt holds at LAP_DEPTH, and FREEZE is still entered.
- FREEZE: cnt_en=1, display shows the snapshot.
  - lap_p -> take a new snapshot, apply the same write rule as RUN, reload the hold counter.
  - start_p -> PAUSE, display returns to live.
  - Otherwise the hold counter decrements; at 0 -> RUN.
  - FREEZE therefore lasts exactly HOLD_CYCLES cycles after the last lap_p.
- PAUSE: cnt_en=0, display live (the counter is frozen).
  - start_p -> RUN.
  - lap_p -> reset sequence: cnt_clr pulse, buffer cleared, -> IDLE. Exception: see LAP_RECALL_EN.
- Buffer:
  - The write pointer never wraps; capture stops when full.
  - The buffer is only cleared by clr or by a reset sequence.
  - Slots can be plain registers.

Optional Feature:
- Macro: STOPWATCH_LAP_RECALL_EN.
- Defined:
  - lap_p in PAUSE with lap_cnt>0 -> RECALL, read pointer=0, display shows slot 0 on the next cycle.
  - In RECALL (cnt_en=0):
    - lap_p advances the read pointer and the display shows the next slot.
    - lap_p while the read pointer == lap_cnt-1 -> reset sequence -> IDLE.
    - start_p -> PAUSE, display returns to live; the buffer is kept.
  - lap_p in PAUSE with lap_cnt=0 -> reset sequence, same as without the macro.
- Undefined:
  - The RECALL state and read pointer are absent.
  - lap_p in PAUSE always performs the reset sequence.
  - State encoding 4 is unused.

Test Plan:
- Reset: assert clr mid-RUN -> state=0, cnt_en=0, dout=0000, lap_cnt=0 immediately, without waiting for a clock edge.
- Start/stop: start_p -> cnt_en=1 next cycle. din=0123, then start_p -> cnt_en=0, state=PAUSE. lap_p -> cnt_clr high for exactly 1 cycle, state=IDLE.
- Freeze timing (HOLD_CYCLES=8): in RUN with din=0042, lap_p -> dout=0042 for 8 cycles while din advances; then dout tracks din. lap_cnt=1.
- Full buffer (LAP_DEPTH=4): 5 lap_p pulses in RUN with din=0010,0020,0030,0040,0050 -> lap_cnt=4, lap_full=1. The fifth lap still freezes and shows 0050.
- Simultaneous: start_p and lap_p together in RUN -> PAUSE, no lap written, no freeze.
- Recall (macro defined): after laps 0011 and 0022, pause. lap_p -> dout=0011; lap_p -> 0022; lap_p -> cnt_clr pulse, IDLE, lap_cnt=0. Macro undefined: first lap_p in PAUSE resets immediately.
